// File: rtl/maxpool_window_ctrl_pkg.sv
// Shared definitions for the 2x2 max-pool window sequencer:
// default lane geometry, FSM state encoding and window position indices.
package maxpool_window_ctrl_pkg;

    // Default lane geometry (LANES = M_CO*M_CI channel lanes per pixel)
    localparam int unsigned MP_LANES  = 4;
    localparam int unsigned MP_MAX_BW = 8;
    localparam int unsigned MP_IMG_W  = 8;
    localparam int unsigned MP_IMG_H  = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } mp_state_e;

    // Positions inside a 2x2 window, in packing order
    localparam int unsigned POS_TL  = 0;
    localparam int unsigned POS_TR  = 1;
    localparam int unsigned POS_BL  = 2;
    localparam int unsigned POS_BR  = 3;
    localparam int unsigned WIN_POS = 4;

    // Width of a counter/address covering 0..n-1 (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of lane/position slot inside a packed window
    function automatic int unsigned win_slot(input int unsigned lane,
                                             input int unsigned pos,
                                             input int unsigned bw);
        return (lane * WIN_POS + pos) * bw;
    endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row line buffer: DEPTH entries of DATA_W bits, one synchronous
// write port and two combinational read ports. Contents need no reset.
module maxpool_line_buf
    import maxpool_window_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = MP_IMG_W,
    parameter int unsigned DATA_W = MP_LANES * MP_MAX_BW,
    parameter int unsigned AW     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_a_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    input  logic [AW-1:0]     rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_b_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store one even-row pixel per accepted write
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

endmodule

// File: rtl/maxpool_window_ctrl.sv
// 2x2 max-pool window sequencer. Buffers an even row, then on the odd row
// assembles each non-overlapping 2x2 window in lane-interleaved packing:
// o_win[(l*4+k)*MAX_BW +: MAX_BW], k = TL,TR,BL,BR.
// Optional feature: define MAXPOOL_WINDOW_CTRL_CNT_EN to add o_win_cnt,
// a saturating count of windows handshaken in the current frame.
module maxpool_window_ctrl
    import maxpool_window_ctrl_pkg::*;
#(
    parameter int unsigned LANES  = MP_LANES,
    parameter int unsigned MAX_BW = MP_MAX_BW,
    parameter int unsigned IMG_W  = MP_IMG_W,
    parameter int unsigned IMG_H  = MP_IMG_H
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic                        i_pix_valid,
    output logic                        o_pix_ready,
    input  logic [LANES*MAX_BW-1:0]     i_pix,
    output logic                        o_win_valid,
    input  logic                        i_win_ready,
    output logic [LANES*4*MAX_BW-1:0]   o_win,
    output logic                        o_busy,
    output logic                        o_frame_done
`ifdef MAXPOOL_WINDOW_CTRL_CNT_EN
    ,
    output logic [15:0]                 o_win_cnt
`endif
);

    localparam int unsigned PIX_W = LANES * MAX_BW;
    localparam int unsigned WIN_W = PIX_W * WIN_POS;
    localparam int unsigned CW    = cnt_w(IMG_W);
    localparam int unsigned RW    = cnt_w(IMG_H);

    mp_state_e          state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [PIX_W-1:0]   held_q;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               win_valid_q, win_valid_d;

    logic               pix_ready;
    logic               pix_acc;
    logic               start_acc;
    logic               win_hs;
    logic               last_pix;
    logic               col_last;
    logic               row_last;
    logic               odd_row;
    logic               odd_col;
    logic               lb_wr;
    logic               held_cap;
    logic               win_reg;
    logic [CW-1:0]      lb_addr_left;
    logic [PIX_W-1:0]   lb_left;
    logic [PIX_W-1:0]   lb_right;

    assign odd_row   = row_q[0];
    assign odd_col   = col_q[0];
    assign col_last  = (col_q == CW'(IMG_W - 1));
    assign row_last  = (row_q == RW'(IMG_H - 1));
    assign last_pix  = col_last && row_last;
    assign start_acc = (state_q == ST_IDLE) && i_start;
    assign pix_acc   = i_pix_valid && pix_ready;
    assign win_hs    = win_valid_q && i_win_ready;
    assign lb_wr     = pix_acc && !odd_row;
    assign held_cap  = pix_acc && odd_row && !odd_col;
    assign win_reg   = pix_acc && odd_row && odd_col;

    // On an odd column the left neighbour is col with bit 0 cleared; this
    // form never addresses outside the buffer even when col is 0.
    assign lb_addr_left = col_q & ~CW'(1);

    maxpool_line_buf #(
        .DEPTH  (IMG_W),
        .DATA_W (PIX_W),
        .AW     (CW)
    ) u_line_buf (
        .clk         (clk),
        .wr_en_i     (lb_wr),
        .wr_addr_i   (col_q),
        .wr_data_i   (i_pix),
        .rd_addr_a_i (lb_addr_left),
        .rd_data_a_o (lb_left),
        .rd_addr_b_i (col_q),
        .rd_data_b_o (lb_right)
    );

    // Input ready: free in RUN except where a window would overwrite an unaccepted one
    always_comb begin
        pix_ready = 1'b0;
        if (state_q == ST_RUN) begin
            if (odd_row && odd_col) begin
                pix_ready = !win_valid_q || i_win_ready;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    assign o_pix_ready = pix_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, busy and end-of-frame pulse
    always_comb begin
        state_d      = state_q;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (pix_acc && last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (win_hs) begin
                    state_d      = ST_IDLE;
                    o_frame_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Raster position next state: advance on accepts, clear on frame start
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_acc) begin
            col_d = '0;
            row_d = '0;
        end else if (pix_acc) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Raster position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Assemble the candidate window in lane-interleaved order
    always_comb begin
        win_d = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            win_d[win_slot(l, POS_TL, MAX_BW) +: MAX_BW] = lb_left[l*MAX_BW +: MAX_BW];
            win_d[win_slot(l, POS_TR, MAX_BW) +: MAX_BW] = lb_right[l*MAX_BW +: MAX_BW];
            win_d[win_slot(l, POS_BL, MAX_BW) +: MAX_BW] = held_q[l*MAX_BW +: MAX_BW];
            win_d[win_slot(l, POS_BR, MAX_BW) +: MAX_BW] = i_pix[l*MAX_BW +: MAX_BW];
        end
    end

    // Output valid: set on registration, which wins over a same-cycle accept
    always_comb begin
        win_valid_d = win_valid_q;
        if (win_reg) begin
            win_valid_d = 1'b1;
        end else if (i_win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Held-left pixel and output window registers
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q      <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            if (held_cap) begin
                held_q <= i_pix;
            end
            if (win_reg) begin
                win_q <= win_d;
            end
            win_valid_q <= win_valid_d;
        end
    end

    assign o_win       = win_q;
    assign o_win_valid = win_valid_q;

`ifdef MAXPOOL_WINDOW_CTRL_CNT_EN
    logic [15:0] win_cnt_q;

    // Per-frame saturating count of handshaken windows
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            win_cnt_q <= '0;
        end else if (win_hs && (win_cnt_q != 16'hFFFF)) begin
            win_cnt_q <= win_cnt_q + 16'd1;
        end
    end

    assign o_win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Scoreboard bench for maxpool_window_ctrl (LANES=2, 4x4 frame).
// Optional o_win_cnt checks compile in with MAXPOOL_WINDOW_CTRL_CNT_EN.
module tb_maxpool_window_ctrl;

    localparam int LANES  = 2;
    localparam int MAX_BW = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int PIX_W  = LANES * MAX_BW;
    localparam int WIN_W  = PIX_W * 4;
    localparam int NWIN   = (IMG_W / 2) * (IMG_H / 2);

    logic              clk = 1'b0;
    logic              reset;
    logic              i_start;
    logic              i_pix_valid;
    logic              o_pix_ready;
    logic [PIX_W-1:0]  i_pix;
    logic              o_win_valid;
    logic              i_win_ready = 1'b1;
    logic [WIN_W-1:0]  o_win;
    logic              o_busy;
    logic              o_frame_done;
`ifdef MAXPOOL_WINDOW_CTRL_CNT_EN
    logic [15:0]       o_win_cnt;
`endif

    always #5 clk = ~clk;

    maxpool_window_ctrl #(
        .LANES  (LANES),
        .MAX_BW (MAX_BW),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .i_pix        (i_pix),
        .o_win_valid  (o_win_valid),
        .i_win_ready  (i_win_ready),
        .o_win        (o_win),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
`ifdef MAXPOOL_WINDOW_CTRL_CNT_EN
        ,
        .o_win_cnt    (o_win_cnt)
`endif
    );

    typedef struct {
        logic [WIN_W-1:0] win;
        bit               last;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt   = 0;
    int   pass_cnt  = 0;
    int   done_cnt  = 0;
    int   rdy_mode  = 0;   // 0: ready high, 1: random, 2: ready low
    bit   after_done = 1'b0;

    task automatic check(input string name, input logic [WIN_W-1:0] act,
                         input logic [WIN_W-1:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Pixel value: lane0 = base + raster index + 1, lane1 = lane0 + 0x80
    function automatic logic [PIX_W-1:0] pix_val(input int base, input int r, input int c);
        logic [7:0] l0;
        l0 = 8'(base + r * IMG_W + c + 1);
        return {l0 + 8'h80, l0};
    endfunction

    function automatic logic [WIN_W-1:0] win_val(input int base, input int pr, input int pc);
        logic [PIX_W-1:0] p [4];
        logic [WIN_W-1:0] w;
        p[0] = pix_val(base, 2*pr,     2*pc);
        p[1] = pix_val(base, 2*pr,     2*pc + 1);
        p[2] = pix_val(base, 2*pr + 1, 2*pc);
        p[3] = pix_val(base, 2*pr + 1, 2*pc + 1);
        w = '0;
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < 4; k++)
                w[(l*4 + k)*MAX_BW +: MAX_BW] = p[k][l*MAX_BW +: MAX_BW];
        return w;
    endfunction

    task automatic push_frame(input int base);
        exp_t e;
        for (int pr = 0; pr < IMG_H/2; pr++)
            for (int pc = 0; pc < IMG_W/2; pc++) begin
                e.win  = win_val(base, pr, pc);
                e.last = (pr == IMG_H/2 - 1) && (pc == IMG_W/2 - 1);
                exp_q.push_back(e);
            end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pix(input logic [PIX_W-1:0] d);
        int n;
        i_pix       = d;
        i_pix_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_pix_ready) break;
            n++;
            if (n >= 100) begin
                check("pix_accept_timeout", 1'b0, 1'b1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        i_pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int maxgap);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
                send_pix(pix_val(base, r, c));
            end
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1'b1);
    endtask

    task automatic wait_done();
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", (done_cnt != start_cnt), 1'b1);
        check("windows_outstanding", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"},  o_pix_ready,  1'b0);
        check({tag, "_win_valid"},  o_win_valid,  1'b0);
        check({tag, "_win"},        o_win,        '0);
        check({tag, "_busy"},       o_busy,       1'b0);
        check({tag, "_frame_done"}, o_frame_done, 1'b0);
`ifdef MAXPOOL_WINDOW_CTRL_CNT_EN
        check({tag, "_win_cnt"},    o_win_cnt,    '0);
`endif
    endtask

    // Window-ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       i_win_ready = 1'b1;
                1:       i_win_ready = 1'($urandom_range(0, 1));
                default: i_win_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on every window handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (after_done) begin
                after_done = 1'b0;
                check("busy_after_done", o_busy, 1'b0);
`ifdef MAXPOOL_WINDOW_CTRL_CNT_EN
                check("win_cnt_final", o_win_cnt, NWIN);
`endif
            end
            if (o_win_valid && i_win_ready) begin
                if (exp_q.size() == 0) begin
                    check("window_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("window", o_win, e.win);
                    check("frame_done_on_handshake", o_frame_done, e.last);
                end
            end else if (o_frame_done) begin
                check("frame_done_spurious", 1'b1, 1'b0);
            end
            if (o_frame_done) begin
                done_cnt++;
                after_done = 1'b1;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset       = 1'b1;
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
        i_pix       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // IDLE ignores pixels
        i_pix       = 16'hFFFF;
        i_pix_valid = 1'b1;
        @(negedge clk);
        check("idle_pix_ready", o_pix_ready, 1'b0);
        check("idle_busy", o_busy, 1'b0);
        @(posedge clk); #1;
        i_pix_valid = 1'b0;

        // Back-to-back frame with ready held high
        push_frame(0);
        start_frame();
        send_frame(0, 0);
        wait_done();

        // Backpressure: first window must hold while the BR pixel at (1,3) stalls
        rdy_mode = 2;
        idle(2);
        push_frame(0);
        start_frame();
        for (int i = 0; i < 7; i++) send_pix(pix_val(0, i / IMG_W, i % IMG_W));
        i_pix       = pix_val(0, 1, 3);
        i_pix_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_pix_ready", o_pix_ready, 1'b0);
            check("bp_win_valid", o_win_valid, 1'b1);
            check("bp_win_hold",  o_win, 64'h86858281_06050201);
        end
        rdy_mode = 0;
        send_pix(pix_val(0, 1, 3));
        rdy_mode = 1;
        for (int r = 2; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) send_pix(pix_val(0, r, c));
        wait_done();

        // Random gaps and ready, with a stray i_start mid-frame
        rdy_mode = 1;
        push_frame(8'h20);
        start_frame();
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            if (i == 5) begin
                @(posedge clk); #1;
                i_start = 1'b1;
                @(posedge clk); #1;
                i_start = 1'b0;
            end
            idle(int'($urandom_range(0, 2)));
            send_pix(pix_val(8'h20, i / IMG_W, i % IMG_W));
        end
        wait_done();

        // Reset mid-frame with a window pending
        rdy_mode = 2;
        idle(2);
        start_frame();
        for (int i = 0; i < 6; i++) send_pix(pix_val(8'h40, i / IMG_W, i % IMG_W));
        @(negedge clk);
        check("pending_before_reset", o_win_valid, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        reset    = 1'b0;
        rdy_mode = 0;
        i_pix_valid = 1'b1;
        @(negedge clk);
        check("abort_needs_start", o_pix_ready, 1'b0);
        @(posedge clk); #1;
        i_pix_valid = 1'b0;

        // Fresh frame after abort
        push_frame(8'h50);
        start_frame();
        send_frame(8'h50, 1);
        wait_done();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/maxpool_window_ctrl.md
# maxpool_window_ctrl

Sequencer that feeds the 2x2 max-pooling datapath from a raster-scan stream of convolution-output pixels. It buffers one even row in a line buffer. On the following odd row it assembles each non-overlapping 2x2 window and presents it in the lane-interleaved packing the pooling datapath consumes. It sits between the convolution core output and the max-pooling stage, and applies valid/ready backpressure in both directions.

## Interface
- LANES, 4, parallel channel lanes per pixel (M_CO*M_CI)
- MAX_BW, 8, bits per lane value
- IMG_W, 8, frame width in pixels; even, >= 2
- IMG_H, 8, frame height in rows; even, >= 2
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle frame start; honoured only in IDLE
- i_pix_valid  in  1  input pixel valid
- o_pix_ready  out  1  input pixel ready
- i_pix  in  LANES*MAX_BW  pixel; lane l at [l*MAX_BW +: MAX_BW]
- o_win_valid  out  1  window valid to pooling datapath
- i_win_ready  in  1  pooling datapath accepts window
- o_win  out  LANES*4*MAX_BW  packed 2x2 window
- o_busy  out  1  high outside IDLE
- o_frame_done  out  1  one-cycle pulse when the frame's last window is accepted

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on i_start.
  - RUN -> DRAIN when the last pixel (row IMG_H-1, col IMG_W-1) is accepted.
  - DRAIN -> IDLE when the pending window is accepted. o_frame_done pulses that cycle.
- Pixel accept = i_pix_valid && o_pix_ready. Only accepts advance the col/row counters.
- col wraps IMG_W-1 -> 0 and increments row. row wraps after IMG_H-1. Both clear on i_start.
- Even row: pixel written to line buffer entry col. o_pix_ready = 1 in RUN.
- Odd row, even col: pixel captured into held-left register. o_pix_ready = 1.
- Odd row, odd col: o_pix_ready = (!o_win_valid || i_win_ready). On accept, the window is registered as follows:
  - TL = lb[col-1]
  - TR = lb[col]
  - BL = held-left
  - BR = i_pix
- Packing rule for each lane l and position k (TL=0, TR=1, BL=2, BR=3): o_win[(l*4+k)*MAX_BW +: MAX_BW].
- o_win_valid sets on window registration. It clears on i_win_ready unless a new window registers in the same cycle.
- o_win holds stable while o_win_valid && !i_win_ready.
- Window emission order is raster over the pooled grid: (IMG_W/2)*(IMG_H/2) windows per frame.
- IDLE: o_pix_ready = 0. i_pix_valid is ignored.
- i_start in RUN or DRAIN is ignored.
- Values pass through unmodified; no arithmetic on data.

## Timing
- Reset values: o_pix_ready=0, o_win_valid=0, o_win=0, o_busy=0, o_frame_done=0, state IDLE, counters 0. Line buffer contents are don't-care.
- Reset mid-frame aborts immediately. The pending window is discarded, and the next frame requires i_start.
- Latency: o_win_valid rises the cycle after the BR pixel accept.
- Throughput: one pixel per cycle with i_win_ready held high.
- Simultaneous window acceptance and new window registration: o_win_valid stays high and o_win updates.
- o_frame_done asserts in the same cycle as the final window handshake. o_busy drops the next cycle.

## Configuration
- MAXPOOL_WINDOW_CTRL_CNT_EN defined: adds output port o_win_cnt (16 bits).
  - Counts windows handshaken to the datapath in the current frame.
  - Cleared on reset and on accepted i_start; saturates at 16'hFFFF.
  - Holds its final value after o_frame_done.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package/header (alongside the CNN core defines) holds LANES and MAX_BW defaults, the state encoding localparams, and window position indices TL/TR/BL/BR = 0..3.
- Sub-module maxpool_line_buf: IMG_W x (LANES*MAX_BW) register array with one write port and two combinational read ports (col-1, col).
- The FSM, counters, held-left register and output register live in the top module.

## Test plan
- Basic frame: LANES=1, MAX_BW=8, IMG_W=4, IMG_H=2, stream pixels 1..8 with ready high -> o_win = {8'd6,8'd5,8'd2,8'd1} then {8'd8,8'd7,8'd4,8'd3}, and o_frame_done on the second handshake.
- Backpressure: same frame, i_win_ready=0 for 5 cycles after the first window -> o_win holds 0x06050201. o_pix_ready=0 at odd-row odd col 3 until acceptance. No pixel is lost.
- Lane packing: LANES=2, pixels with lane1 = lane0 + 0x80 -> lane1 occupies bits [63:32] with TL..BR order; verify each byte.
- Full frame: 8x8, random valid gaps -> exactly 16 windows, then o_frame_done; o_busy low one cycle later. With CNT_EN defined, o_win_cnt = 16.
- Control boundaries:
  - i_start pulsed mid-RUN -> ignored; counters unaffected.
  - reset asserted after 5 pixels -> all outputs at reset values next cycle.
  - A fresh i_start then produces a correct frame.
